mvm_uart_cmd_system: RTL

MVM_UART_CMD_SYSTEM -- requirements
Module: mvm_uart_cmd_system

---
 rtl/mvm_uart_pkg.sv | 25 ++
 rtl/axis_matvec_mul.sv | 64 ++++++
 rtl/mvm_uart_byte_ser.sv | 41 ++++
 rtl/uart_rx.sv | 83 ++++++++
 rtl/uart_tx.sv | 48 ++++
 rtl/mvm_uart_cmd_system.sv | 251 +++++++++++++++++++++++++
 6 files changed

// File: rtl/mvm_uart_pkg.sv
// Shared definitions for the UART-attached matrix-vector multiplier.
// Holds the command codes, response codes and the controller state encoding.
package mvm_uart_pkg;

    localparam logic [7:0] CMD_LOAD_K       = 8'hA1;
    localparam logic [7:0] CMD_RUN_X        = 8'hA2;
    localparam logic [7:0] CMD_LOAD_K_RUN_X = 8'hA3;

    localparam logic [7:0] RSP_ACK     = 8'h06;
    localparam logic [7:0] RSP_BAD_CHK = 8'hE1;
    localparam logic [7:0] RSP_BAD_CMD = 8'hE2;
    localparam logic [7:0] RSP_NO_K    = 8'hE3;

    typedef enum logic [2:0] {
        IDLE,
        RX_K,
        RX_X,
        RX_CHK,
        START,
        WAIT_Y,
        TX_Y,
        TX_RSP
    } state_t;

endpackage

// File: rtl/axis_matvec_mul.sv
// Signed matrix-vector multiply y = K * x with valid/ready in and out.
// Ports: clk, rstn, s_valid/s_ready with k_flat (element r*C+c at bits
//        [(r*C+c)*W_K +: W_K]) and x_flat, m_valid/m_ready with y_flat
//        (row r at [r*WY +: WY], WY = W_X+W_K+clog2(C)).
module axis_matvec_mul #(
    parameter int R   = 8,
    parameter int C   = 8,
    parameter int W_X = 8,
    parameter int W_K = 8
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    input  logic [R*C*W_K-1:0]                    k_flat,
    input  logic [C*W_X-1:0]                      x_flat,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic [R*(W_X+W_K+$clog2(C))-1:0]      y_flat
);

    localparam int WY = W_X + W_K + $clog2(C);
    localparam int PW = W_X + W_K;

    logic [R*WY-1:0]        y_next;
    logic signed [W_K-1:0]  kv;
    logic signed [W_X-1:0]  xv;
    logic signed [PW-1:0]   prod;
    logic signed [WY-1:0]   acc;

    always_comb begin
        y_next = '0;
        kv     = '0;
        xv     = '0;
        prod   = '0;
        acc    = '0;
        for (int r = 0; r < R; r++) begin
            acc = '0;
            for (int c = 0; c < C; c++) begin
                kv   = k_flat[(r*C+c)*W_K +: W_K];
                xv   = x_flat[c*W_X +: W_X];
                prod = PW'(kv) * PW'(xv);
                acc  = acc + WY'(prod);
            end
            y_next[r*WY +: WY] = acc;
        end
    end

    // One result in flight: the input side is blocked until y is taken.
    assign s_ready = !m_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            y_flat  <= '0;
        end else if (s_valid && s_ready) begin
            m_valid <= 1'b1;
            y_flat  <= y_next;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mvm_uart_byte_ser.sv
// Loads a wide word and hands it out one byte at a time, least-significant
// byte first, under a valid/ready handshake.
// Ports: clk, rstn, load/din (capture NBITS), m_data/m_valid/m_ready (byte
//        out), m_last (the byte on m_data is the final one).
module mvm_uart_byte_ser #(
    parameter int NBITS = 64
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [NBITS-1:0] din,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);

    localparam int NBYTES = NBITS / 8;
    localparam int NW     = $clog2(NBYTES + 1);

    logic [NBITS-1:0] sreg;
    logic [NW-1:0]    left;

    assign m_data  = sreg[7:0];
    assign m_valid = (left != '0);
    assign m_last  = (left == NW'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sreg <= '0;
            left <= '0;
        end else if (load) begin
            sreg <= din;
            left <= NW'(NBYTES);
        end else if (m_valid && m_ready) begin
            sreg <= sreg >> 8;
            left <= left - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style framing, LSB first.
// Ports: clk, rstn (async active-low), rx (serial line),
//        m_data/m_valid (received word, m_valid is a one-cycle pulse).
module uart_rx #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx,
    output logic [BITS_PER_WORD-1:0] m_data,
    output logic                     m_valid
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int BW = $clog2(BITS_PER_WORD + 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t              state;
    logic                   rx_meta;
    logic                   rx_sync;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          nbit;
    logic [BITS_PER_WORD-1:0] shreg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= R_IDLE;
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            cnt     <= '0;
            nbit    <= '0;
            shreg   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            m_valid <= 1'b0;
            case (state)
                R_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) state <= R_START;
                end
                // Re-check the line half a bit in so a glitch is not taken as a start bit.
                R_START: begin
                    if (cnt == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
                        cnt   <= '0;
                        nbit  <= '0;
                        state <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[BITS_PER_WORD-1:1]};
                        nbit  <= nbit + 1'b1;
                        if (nbit == BW'(BITS_PER_WORD - 1)) state <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
                        cnt   <= '0;
                        state <= R_IDLE;
                        // A low stop bit is a framing error; the word is discarded.
                        if (rx_sync) begin
                            m_data  <= shreg;
                            m_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, one start bit, LSB-first data, one stop bit.
// Ports: clk, rstn (async active-low), s_data/s_valid/s_ready (word in),
//        tx (serial line, idles high, driven straight from a flop).
module uart_tx #(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [BITS_PER_WORD-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     tx
);

    localparam int FW = BITS_PER_WORD + 2;
    localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int LW = $clog2(FW + 1);

    logic [FW-1:0] frame;
    logic [CW-1:0] cnt;
    logic [LW-1:0] left;

    assign s_ready = (left == '0);
    assign tx      = frame[0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame <= '1;
            cnt   <= '0;
            left  <= '0;
        end else if (left == '0) begin
            if (s_valid) begin
                frame <= {1'b1, s_data, 1'b0};
                left  <= LW'(FW);
                cnt   <= '0;
            end
        end else if (cnt == CW'(CLOCKS_PER_PULSE - 1)) begin
            // Shifting ones in leaves the line high once the stop bit is out.
            cnt   <= '0;
            frame <= {1'b1, frame[FW-1:1]};
            left  <= left - 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mvm_uart_cmd_system.sv
// Byte-framed UART front end for a matrix-vector multiplier.
// Frames: command, payload, XOR checksum. LOAD_K stores the matrix, RUN_X
// multiplies the committed matrix by x and returns y sign-extended,
// LOAD_K_RUN_X does both. Single-byte status codes report the other outcomes.
// Ports: clk, rstn (async active-low), rx/tx (UART lines),
//        busy (controller not in IDLE), err (one-cycle pulse on timeout or a
//        dropped byte), k_loaded (a matrix has been committed since reset).
// Every internal stream (uart_tx input, core input/output, serializer output)
// transfers exactly on a cycle where valid and ready are both high; a valid
// source holds its data until that cycle.
module mvm_uart_cmd_system
    import mvm_uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int BITS_PER_WORD    = 8,
    parameter int R                = 8,
    parameter int C                = 8,
    parameter int W_X              = 8,
    parameter int W_K              = 8,
    parameter int W_Y_OUT          = 32,
    parameter int TIMEOUT_CYCLES   = 16 * CLOCKS_PER_PULSE * 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx,
    output logic tx,
    output logic busy,
    output logic err,
    output logic k_loaded
);

    localparam int W_Y       = W_X + W_K + $clog2(C);
    localparam int K_BYTES   = R * C * W_K / 8;
    localparam int X_BYTES   = C * W_X / 8;
    localparam int MAX_BYTES = (K_BYTES > X_BYTES) ? K_BYTES : X_BYTES;
    localparam int BCW       = $clog2(MAX_BYTES + 1);
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    if ((W_X % 8) != 0 || (W_K % 8) != 0 || (W_Y_OUT % 8) != 0 ||
        W_Y_OUT < W_Y || BITS_PER_WORD != 8) begin : g_bad_params
        $error("mvm_uart_cmd_system: widths must be byte multiples and W_Y_OUT must hold the full y");
    end

    state_t              state;
    logic [7:0]          cmd;
    logic [7:0]          chk;
    logic [7:0]          rsp;
    logic [BCW-1:0]      cnt;
    logic [TW-1:0]       tmr;
    logic [K_BYTES*8-1:0] k_stage;
    logic [K_BYTES*8-1:0] k_com;
    logic [X_BYTES*8-1:0] x_buf;

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;

    logic                core_s_valid;
    logic                core_s_ready;
    logic                core_m_valid;
    logic                core_m_ready;
    logic [R*W_Y-1:0]    y_flat;
    logic [R*W_Y_OUT-1:0] y_ext;
    logic signed [W_Y-1:0] y_elem;

    logic [7:0]          ser_data;
    logic                ser_valid;
    logic                ser_ready;
    logic                ser_last;
    logic                ser_load;

    uart_rx #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .BITS_PER_WORD    (BITS_PER_WORD)
    ) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .rx      (rx),
        .m_data  (rx_data),
        .m_valid (rx_valid)
    );

    uart_tx #(
        .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
        .BITS_PER_WORD    (BITS_PER_WORD)
    ) u_tx (
        .clk     (clk),
        .rstn    (rstn),
        .s_data  (tx_data),
        .s_valid (tx_valid),
        .s_ready (tx_ready),
        .tx      (tx)
    );

    axis_matvec_mul #(
        .R   (R),
        .C   (C),
        .W_X (W_X),
        .W_K (W_K)
    ) u_core (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (core_s_valid),
        .s_ready (core_s_ready),
        .k_flat  (k_com),
        .x_flat  (x_buf),
        .m_valid (core_m_valid),
        .m_ready (core_m_ready),
        .y_flat  (y_flat)
    );

    mvm_uart_byte_ser #(
        .NBITS (R * W_Y_OUT)
    ) u_ser (
        .clk     (clk),
        .rstn    (rstn),
        .load    (ser_load),
        .din     (y_ext),
        .m_data  (ser_data),
        .m_valid (ser_valid),
        .m_ready (ser_ready),
        .m_last  (ser_last)
    );

    always_comb begin
        y_ext  = '0;
        y_elem = '0;
        for (int r = 0; r < R; r++) begin
            y_elem = y_flat[r*W_Y +: W_Y];
            y_ext[r*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(y_elem);
        end
    end

    assign busy         = (state != IDLE);
    assign core_s_valid = (state == START);
    assign core_m_ready = (state == WAIT_Y);
    // The serializer doubles as the y capture register.
    assign ser_load     = (state == WAIT_Y) && core_m_valid;
    assign ser_ready    = (state == TX_Y) && tx_ready;
    assign tx_valid     = (state == TX_RSP) || ((state == TX_Y) && ser_valid);
    assign tx_data      = (state == TX_RSP) ? rsp : ser_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cmd      <= '0;
            chk      <= '0;
            rsp      <= '0;
            cnt      <= '0;
            tmr      <= '0;
            k_stage  <= '0;
            k_com    <= '0;
            x_buf    <= '0;
            k_loaded <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            // Bytes arriving while the result is being produced or sent are lost.
            if (rx_valid && (state inside {START, WAIT_Y, TX_Y, TX_RSP})) err <= 1'b1;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cmd <= rx_data;
                        chk <= rx_data;
                        cnt <= '0;
                        tmr <= '0;
                        if (rx_data == CMD_LOAD_K || rx_data == CMD_LOAD_K_RUN_X) begin
                            state <= RX_K;
                        end else if (rx_data == CMD_RUN_X) begin
                            state <= RX_X;
                        end else begin
                            rsp   <= RSP_BAD_CMD;
                            state <= TX_RSP;
                        end
                    end
                end
                RX_K, RX_X, RX_CHK: begin
                    if (rx_valid) begin
                        tmr <= '0;
                        chk <= chk ^ rx_data;
                        case (state)
                            RX_K: begin
                                k_stage[cnt*8 +: 8] <= rx_data;
                                if (cnt == BCW'(K_BYTES - 1)) begin
                                    cnt   <= '0;
                                    state <= (cmd == CMD_LOAD_K_RUN_X) ? RX_X : RX_CHK;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                            RX_X: begin
                                x_buf[cnt*8 +: 8] <= rx_data;
                                if (cnt == BCW'(X_BYTES - 1)) begin
                                    cnt   <= '0;
                                    state <= RX_CHK;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                            default: begin
                                // chk still holds the XOR of command and payload here.
                                if (rx_data != chk) begin
                                    rsp   <= RSP_BAD_CHK;
                                    state <= TX_RSP;
                                end else begin
                                    if (cmd != CMD_RUN_X) begin
                                        k_com    <= k_stage;
                                        k_loaded <= 1'b1;
                                    end
                                    if (cmd == CMD_LOAD_K) begin
                                        rsp   <= RSP_ACK;
                                        state <= TX_RSP;
                                    end else if (cmd == CMD_RUN_X && !k_loaded) begin
                                        rsp   <= RSP_NO_K;
                                        state <= TX_RSP;
                                    end else begin
                                        state <= START;
                                    end
                                end
                            end
                        endcase
                    end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                        err   <= 1'b1;
                        cnt   <= '0;
                        tmr   <= '0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                START: begin
                    if (core_s_ready) state <= WAIT_Y;
                end
                WAIT_Y: begin
                    if (core_m_valid) state <= TX_Y;
                end
                TX_Y: begin
                    if (ser_valid && tx_ready && ser_last) state <= IDLE;
                end
                TX_RSP: begin
                    if (tx_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
